// File: rtl/somador_serial_4bits_pkg.sv
// Shared types and sizing for the bit-serial adder.
package somador_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/somador_serial_4bits_somador1bit.sv
// Single-bit combinational full adder, the only arithmetic in the serial datapath.
module Somador1Bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/somador_serial_4bits.sv
// Bit-serial adder: one full adder plus carry flop, LSB first, WIDTH+2 cycles per op.
module somador_serial_4bits
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             C3,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             c3_q, c3_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;

  Somador1Bit u_fa (
    .A    (ra_q[0]),
    .B    (rb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  // Next-state, datapath shift and result capture.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    c3_d    = c3_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = A;
          rb_d    = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rs_d    = WIDTH'({fa_s, rs_q} >> 1);
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: carry_q is the carry into the MSB stage before it updates.
        if (cnt_q == CNT_LAST) begin
          s_d     = WIDTH'({fa_s, rs_q} >> 1);
          cout_d  = fa_co;
          c3_d    = carry_q;
          v_d     = carry_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      c3_q    <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      c3_q    <= c3_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign C3   = c3_q;
  assign V    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
